// File: rtl/csa_pkg.sv
// Shared helpers for the 4:2 compressor tree: log2 sizing, level count and
// the operand-count legality rule.
package csa_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Number of 4:2 compressor rows between the operand inputs and the CPA.
  function automatic int levels(input int num_ops);
    return clog2(num_ops) - 1;
  endfunction

  function automatic bit ops_legal(input int num_ops);
    return (num_ops == 4) || (num_ops == 8) || (num_ops == 16);
  endfunction

endpackage

// File: rtl/csa42_row.sv
// One W-bit row of 4:2 compressors. The carry between the two internal full
// adders ripples exactly one bit position, so the row stays carry-free.
module csa42_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] w,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-1:0] t;
  logic [W-1:0] ci;

  assign t = w ^ x ^ y;

  // First-adder carry of bit i is the cin of bit i+1; the MSB carry drops out.
  assign ci = {(w[W-2:0] & x[W-2:0]) | (w[W-2:0] & y[W-2:0]) | (x[W-2:0] & y[W-2:0]),
               1'b0};

  assign s = t ^ z ^ ci;

  assign c = {(t[W-2:0] & z[W-2:0]) | (t[W-2:0] & ci[W-2:0]) | (z[W-2:0] & ci[W-2:0]),
              1'b0};

endmodule

// File: rtl/csa42_tree_pipe.sv
// Pipelined multi-operand adder: rows of 4:2 compressors, one register per
// level, then a registered carry-propagate add. Global stall, sync flush.
module csa42_tree_pipe
  import csa_pkg::*;
#(
  parameter  int DW      = 8,
  parameter  int NUM_OPS = 8,
  parameter  bit SIGNED  = 1'b0,
  localparam int OW      = DW + clog2(NUM_OPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_OPS*DW-1:0] in_ops,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_sum
);

  localparam int LEVELS = levels(NUM_OPS);
  localparam int HALF   = NUM_OPS / 2;

  if (!ops_legal(NUM_OPS)) begin : g_bad_num_ops
    $error("csa42_tree_pipe: NUM_OPS must be 4, 8 or 16");
  end

  if (DW < 2) begin : g_bad_dw
    $error("csa42_tree_pipe: DW must be at least 2");
  end

  logic [OW-1:0]     ext [NUM_OPS];
  logic [OW-1:0]     nxt [LEVELS][HALF];
  logic [OW-1:0]     stg [LEVELS][HALF];
  logic [LEVELS-1:0] vld;
  logic              adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (SIGNED) begin
        ext[i] = {{(OW-DW){in_ops[i*DW + DW - 1]}}, in_ops[i*DW +: DW]};
      end else begin
        ext[i] = {{(OW-DW){1'b0}}, in_ops[i*DW +: DW]};
      end
    end
  end

  // Level k consumes NUM_OPS>>k vectors and yields half as many.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int ROWS = NUM_OPS >> (k + 2);
    for (genvar g = 0; g < ROWS; g++) begin : g_row
      logic [OW-1:0] src [4];

      for (genvar j = 0; j < 4; j++) begin : g_src
        if (k == 0) begin : g_from_in
          assign src[j] = ext[4*g + j];
        end else begin : g_from_stg
          assign src[j] = stg[k-1][4*g + j];
        end
      end

      csa42_row #(
        .W (OW)
      ) u_row (
        .w (src[0]),
        .x (src[1]),
        .y (src[2]),
        .z (src[3]),
        .s (nxt[k][2*g]),
        .c (nxt[k][2*g + 1])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        for (int unsigned j = 0; j < HALF; j++) begin
          stg[k][j] <= '0;
        end
      end
    end else if (flush) begin
      vld       <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int unsigned k = 1; k < LEVELS; k++) begin
        vld[k] <= vld[k-1];
      end
      // Only the live slots of each level are loaded; the rest stay at reset.
      for (int unsigned k = 0; k < LEVELS; k++) begin
        for (int unsigned j = 0; j < HALF; j++) begin
          if (j < (NUM_OPS >> (k + 1))) begin
            stg[k][j] <= nxt[k][j];
          end
        end
      end
      out_valid <= vld[LEVELS-1];
      out_sum   <= stg[LEVELS-1][0] + stg[LEVELS-1][1];
    end
  end

endmodule

// File: tb/tb_csa42_tree_pipe.sv
// Bench for csa42_tree_pipe: three configurations (8x8 unsigned, 4x8 signed,
// 16x4 unsigned) checked against plain-arithmetic sums.
`timescale 1ns/1ps
module tb_csa42_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush;

  logic        u8_in_valid, u8_in_ready, u8_out_valid, u8_out_ready;
  logic [63:0] u8_in_ops;
  logic [10:0] u8_out_sum;

  logic        u4_in_valid, u4_in_ready, u4_out_valid, u4_out_ready;
  logic [31:0] u4_in_ops;
  logic [9:0]  u4_out_sum;

  logic        u16_in_valid, u16_in_ready, u16_out_valid, u16_out_ready;
  logic [63:0] u16_in_ops;
  logic [7:0]  u16_out_sum;

  csa42_tree_pipe #(.DW(8), .NUM_OPS(8), .SIGNED(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(u8_in_valid), .in_ready(u8_in_ready), .in_ops(u8_in_ops),
    .out_valid(u8_out_valid), .out_ready(u8_out_ready), .out_sum(u8_out_sum)
  );

  csa42_tree_pipe #(.DW(8), .NUM_OPS(4), .SIGNED(1'b1)) u_dut4s (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(u4_in_valid), .in_ready(u4_in_ready), .in_ops(u4_in_ops),
    .out_valid(u4_out_valid), .out_ready(u4_out_ready), .out_sum(u4_out_sum)
  );

  csa42_tree_pipe #(.DW(4), .NUM_OPS(16), .SIGNED(1'b0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(u16_in_valid), .in_ready(u16_in_ready), .in_ops(u16_in_ops),
    .out_valid(u16_out_valid), .out_ready(u16_out_ready), .out_sum(u16_out_sum)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] ref8(input logic [63:0] ops);
    int unsigned acc;
    acc = 0;
    for (int i = 0; i < 8; i++) acc += ops[i*8 +: 8];
    return 11'(acc);
  endfunction

  function automatic logic [9:0] ref4s(input logic [31:0] ops);
    int acc;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += $signed(ops[i*8 +: 8]);
    return 10'(acc);
  endfunction

  function automatic logic [7:0] ref16(input logic [63:0] ops);
    int unsigned acc;
    acc = 0;
    for (int i = 0; i < 16; i++) acc += ops[i*4 +: 4];
    return 8'(acc);
  endfunction

  // Scoreboard for the 8x8 instance: handshakes observed mid-cycle.
  logic [10:0] exp_q [$];
  int          u8_pushed = 0;
  int          u8_popped = 0;
  logic        hold_v = 1'b0;
  logic [10:0] hold_s = '0;
  logic [10:0] exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("u8_stall_valid", u8_out_valid, 1);
        chk("u8_stall_sum", u8_out_sum, hold_s);
      end
      hold_v = u8_out_valid && !u8_out_ready;
      hold_s = u8_out_sum;
      if (u8_out_valid && u8_out_ready) begin
        u8_popped++;
        if (exp_q.size() == 0) begin
          chk("u8_unexpected_result", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          chk("u8_sum", u8_out_sum, exp_v);
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (u8_in_valid && u8_in_ready) begin
        exp_q.push_back(ref8(u8_in_ops));
        u8_pushed++;
      end
    end
  end

  typedef struct {
    logic [31:0] ops;
    logic [9:0]  sum;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int          sent, base_pop, base_push, n;
    logic [7:0]  e16;

    tbl[0] = '{32'h80808080, 10'h200};
    tbl[1] = '{32'h0100FF7F, 10'h07F};
    tbl[2] = '{32'h7F7F7F7F, 10'h1FC};
    tbl[3] = '{32'hFFFFFFFF, 10'h3FC};
    tbl[4] = '{32'h01020304, 10'h00A};
    tbl[5] = '{32'h7F807F80, 10'h3FE};
    for (int i = 6; i < 12; i++) begin
      tbl[i].ops = $urandom;
      tbl[i].sum = ref4s(tbl[i].ops);
    end

    rst_n = 1'b0;
    flush = 1'b0;
    u8_in_valid  = 1'b0; u8_in_ops  = '0; u8_out_ready  = 1'b1;
    u4_in_valid  = 1'b0; u4_in_ops  = '0; u4_out_ready  = 1'b1;
    u16_in_valid = 1'b0; u16_in_ops = '0; u16_out_ready = 1'b1;

    #12;
    chk("rst_u8_out_valid", u8_out_valid, 0);
    chk("rst_u8_out_sum", u8_out_sum, 0);
    chk("rst_u8_in_ready", u8_in_ready, 1);
    chk("rst_u4_out_sum", u4_out_sum, 0);
    chk("rst_u16_out_valid", u16_out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single all-ones set: result visible exactly three cycles on.
    u8_in_ops   = {8{8'hFF}};
    u8_in_valid = 1'b1;
    tick();
    u8_in_valid = 1'b0;
    chk("lat_c1", u8_out_valid, 0);
    tick();
    chk("lat_c2", u8_out_valid, 0);
    tick();
    chk("lat_c3_valid", u8_out_valid, 1);
    chk("lat_c3_sum", u8_out_sum, 11'h7F8);
    tick();
    chk("lat_c4", u8_out_valid, 0);

    // 20 back-to-back sets at full rate.
    base_pop = u8_popped;
    for (int i = 0; i < 20; i++) begin
      u8_in_ops   = {$urandom, $urandom};
      u8_in_valid = 1'b1;
      #1;
      chk("b2b_in_ready", u8_in_ready, 1);
      chk("b2b_out_valid", u8_out_valid, (i >= 3));
      tick();
    end
    u8_in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("b2b_tail_valid", u8_out_valid, 1);
      tick();
    end
    chk("b2b_tail_done", u8_out_valid, 0);
    chk("b2b_count", u8_popped - base_pop, 20);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Streaming with a 5-cycle downstream stall.
    base_pop  = u8_popped;
    base_push = u8_pushed;
    sent = 0;
    u8_in_ops   = {$urandom, $urandom};
    u8_in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && sent < 12; cyc++) begin
      u8_out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      if (u8_out_valid && !u8_out_ready) chk("bp_in_ready", u8_in_ready, 0);
      acc = u8_in_ready;
      tick();
      if (acc) begin
        sent++;
        u8_in_ops = {$urandom, $urandom};
      end
    end
    u8_in_valid  = 1'b0;
    u8_out_ready = 1'b1;
    for (n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    tick();
    chk("bp_sent", sent, 12);
    chk("bp_accepted", u8_pushed - base_push, 12);
    chk("bp_delivered", u8_popped - base_pop, 12);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Signed 4-operand vectors.
    for (int i = 0; i < 12; i++) begin
      u4_in_ops   = tbl[i].ops;
      u4_in_valid = 1'b1;
      tick();
      u4_in_valid = 1'b0;
      for (n = 0; n < 8 && !u4_out_valid; n++) tick();
      chk($sformatf("tbl_lat_%0d", i), n, 1);
      chk($sformatf("tbl_sum_%0d", i), u4_out_sum, tbl[i].sum);
      tick();
    end

    // Flush with three sets in flight.
    for (int i = 0; i < 3; i++) begin
      u16_in_ops   = {$urandom, $urandom};
      u16_in_valid = 1'b1;
      tick();
    end
    u16_in_ops = {$urandom, $urandom};
    flush      = 1'b1;
    tick();
    flush        = 1'b0;
    u16_in_valid = 1'b0;
    chk("flush_out_valid", u16_out_valid, 0);
    chk("flush_in_ready", u16_in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("flush_no_ghost", u16_out_valid, 0);
    end
    u16_in_ops   = {$urandom, $urandom};
    e16          = ref16(u16_in_ops);
    u16_in_valid = 1'b1;
    tick();
    u16_in_valid = 1'b0;
    for (n = 0; n < 10 && !u16_out_valid; n++) tick();
    chk("flush_after_lat", n, 3);
    chk("flush_after_sum", u16_out_sum, e16);
    tick();

    // Asynchronous reset while results are streaming out.
    u16_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      u16_in_ops = {$urandom, $urandom} | 64'h1111_1111_1111_1111;
      tick();
    end
    chk("rst_mid_pre_valid", u16_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", u16_out_valid, 0);
    chk("rst_mid_out_sum", u16_out_sum, 0);
    u16_in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_in_ready", u16_in_ready, 1);
    u16_in_ops   = {16{4'h1}};
    u16_in_valid = 1'b1;
    tick();
    u16_in_valid = 1'b0;
    for (n = 0; n < 10 && !u16_out_valid; n++) tick();
    chk("rst_mid_lat", n, 3);
    chk("rst_mid_sum", u16_out_sum, 8'd16);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
